// File: rtl/bitwise_logic_accum_pkg.sv
// Shared op-code definitions for the bitwise logic unit and anything that drives it.
package logic_unit_pkg;

   localparam int LU_OP_W = 3;

   localparam logic [LU_OP_W-1:0] OP_AND   = 3'b000;
   localparam logic [LU_OP_W-1:0] OP_OR    = 3'b001;
   localparam logic [LU_OP_W-1:0] OP_XOR   = 3'b010;
   localparam logic [LU_OP_W-1:0] OP_NOR   = 3'b011;
   localparam logic [LU_OP_W-1:0] OP_NAND  = 3'b100;
   localparam logic [LU_OP_W-1:0] OP_XNOR  = 3'b101;
   localparam logic [LU_OP_W-1:0] OP_ANDN  = 3'b110;
   localparam logic [LU_OP_W-1:0] OP_PASSA = 3'b111;

endpackage

// File: rtl/bitwise_logic_accum_if.sv
// Beat-in / result-out handshake bundle of the bitwise logic accumulator.
interface bitwise_logic_accum_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
);
   import logic_unit_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     data_operandA;
   logic [WIDTH-1:0]     data_operandB;
   logic [LU_OP_W-1:0]   ctrl_op;
   logic                 in_first;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     result;
   logic                 result_zero;
   logic                 result_ones;
   logic [CNT_W-1:0]     beat_count;
   logic                 err_restart;

   modport master (
      output in_valid, data_operandA, data_operandB, ctrl_op, in_first, in_last, out_ready,
      input  in_ready, out_valid, result, result_zero, result_ones, beat_count, err_restart
   );

   modport slave (
      input  in_valid, data_operandA, data_operandB, ctrl_op, in_first, in_last, out_ready,
      output in_ready, out_valid, result, result_zero, result_ones, beat_count, err_restart
   );

endinterface

// File: rtl/bitwise_op_comb.sv
// Purely combinational selectable bitwise operator z = OP(x, y).
module bitwise_op_comb import logic_unit_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic [LU_OP_W-1:0] op,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic [WIDTH-1:0]   z
);

   always_comb begin
      z = x;
      case (op)
         OP_AND:   z = x & y;
         OP_OR:    z = x | y;
         OP_XOR:   z = x ^ y;
         OP_NOR:   z = ~(x | y);
         OP_NAND:  z = ~(x & y);
         OP_XNOR:  z = ~(x ^ y);
         OP_ANDN:  z = x & ~y;
         default:  z = x;
      endcase
   end

endmodule

// File: rtl/bitwise_logic_accum.sv
// Handshaked bitwise logic unit folding multi-beat groups into one registered result.
module bitwise_logic_accum #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input logic clock,
   input logic reset_n,
   bitwise_logic_accum_if.slave bus
);
   import logic_unit_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] acc_cnt;
   logic             group_active;

   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             result_zero_q;
   logic             result_ones_q;
   logic [CNT_W-1:0] beat_count_q;
   logic             err_restart_q;

   logic             accept;
   logic             group_start;
   logic [WIDTH-1:0] beat_val;
   logic [WIDTH-1:0] fold_val;
   logic [WIDTH-1:0] next_val;
   logic [CNT_W-1:0] next_cnt;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign group_start  = bus.in_first || !group_active;

   bitwise_op_comb #(.WIDTH(WIDTH)) u_op_beat (
      .op (bus.ctrl_op),
      .x  (bus.data_operandA),
      .y  (bus.data_operandB),
      .z  (beat_val)
   );

   // Later beats combine the running value with this beat's result using the same op.
   bitwise_op_comb #(.WIDTH(WIDTH)) u_op_fold (
      .op (bus.ctrl_op),
      .x  (acc),
      .y  (beat_val),
      .z  (fold_val)
   );

   always_comb begin
      next_val = fold_val;
      next_cnt = (acc_cnt == CNT_MAX) ? CNT_MAX : acc_cnt + 1'b1;
      if (group_start) begin
         next_val = beat_val;
         next_cnt = CNT_W'(1);
      end
   end

   // An accepted last beat in the handoff cycle reloads the output, keeping out_valid high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc           <= '0;
         acc_cnt       <= '0;
         group_active  <= 1'b0;
         out_valid_q   <= 1'b0;
         result_q      <= '0;
         result_zero_q <= 1'b0;
         result_ones_q <= 1'b0;
         beat_count_q  <= '0;
         err_restart_q <= 1'b0;
      end else begin
         err_restart_q <= accept && bus.in_first && group_active;
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (accept) begin
            if (bus.in_last) begin
               result_q      <= next_val;
               beat_count_q  <= next_cnt;
               result_zero_q <= (next_val == '0);
               result_ones_q <= (next_val == '1);
               out_valid_q   <= 1'b1;
               group_active  <= 1'b0;
            end else begin
               acc          <= next_val;
               acc_cnt      <= next_cnt;
               group_active <= 1'b1;
            end
         end
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.result      = result_q;
   assign bus.result_zero = result_zero_q;
   assign bus.result_ones = result_ones_q;
   assign bus.beat_count  = beat_count_q;
   assign bus.err_restart = err_restart_q;

endmodule

// File: tb/tb_bitwise_logic_accum.sv
// Scoreboard bench: two instances (CNT_W=8 and CNT_W=2) share one stimulus stream.
module tb_bitwise_logic_accum;
   import logic_unit_pkg::*;

   typedef struct {
      logic [31:0] val;
      int          cnt;
   } exp_t;

   logic clock;
   logic reset_n;
   logic rand_ready;
   logic dir_ready;
   logic rnd_ready;

   int n_checks;
   int n_pass;

   exp_t        sb_q[$];
   logic [31:0] m_acc;
   int          m_cnt;
   logic        m_active;
   logic        err_exp;

   logic [31:0] op_exp [8] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F,
                               32'h0FFF_0FFF, 32'hF00F_F00F, 32'h00F0_00F0, 32'hF0F0_F0F0};

   bitwise_logic_accum_if #(.WIDTH(32), .CNT_W(8)) bus8 ();
   bitwise_logic_accum_if #(.WIDTH(32), .CNT_W(2)) bus2 ();

   assign bus8.out_ready     = rand_ready ? rnd_ready : dir_ready;
   assign bus2.out_ready     = bus8.out_ready;
   assign bus2.in_valid      = bus8.in_valid;
   assign bus2.data_operandA = bus8.data_operandA;
   assign bus2.data_operandB = bus8.data_operandB;
   assign bus2.ctrl_op       = bus8.ctrl_op;
   assign bus2.in_first      = bus8.in_first;
   assign bus2.in_last       = bus8.in_last;

   bitwise_logic_accum #(.WIDTH(32), .CNT_W(8)) dut8 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus8)
   );

   bitwise_logic_accum #(.WIDTH(32), .CNT_W(2)) dut2 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus2)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   function automatic logic [31:0] op_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOR:  return ~(a | b);
         OP_NAND: return ~(a & b);
         OP_XNOR: return ~(a ^ b);
         OP_ANDN: return a & ~b;
         default: return a;
      endcase
   endfunction

   function automatic logic [31:0] sat_cnt(input int c, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (c > lim) ? 32'(lim) : 32'(c);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor first (checks what the DUT presents now), then the reference model consumes the beat
   // that will be accepted at the coming rising edge.
   always @(negedge clock) begin
      logic [31:0] r;
      if (reset_n) begin
         check("out_valid_vs_pending", 32'(bus8.out_valid), 32'(sb_q.size() > 0));
         check("out_valid_w2", 32'(bus2.out_valid), 32'(bus8.out_valid));
         check("in_ready_rule", 32'(bus8.in_ready), 32'(!bus8.out_valid || bus8.out_ready));
         check("err_restart", 32'(bus8.err_restart), 32'(err_exp));
         check("err_restart_w2", 32'(bus2.err_restart), 32'(err_exp));
         if (bus8.out_valid && sb_q.size() > 0) begin
            check("sb_result", bus8.result, sb_q[0].val);
            check("sb_result_w2", bus2.result, sb_q[0].val);
            check("sb_zero", 32'(bus8.result_zero), 32'(sb_q[0].val == 32'h0));
            check("sb_ones", 32'(bus8.result_ones), 32'(sb_q[0].val == 32'hFFFF_FFFF));
            check("sb_count", 32'(bus8.beat_count), sat_cnt(sb_q[0].cnt, 8));
            check("sb_count_w2", 32'(bus2.beat_count), sat_cnt(sb_q[0].cnt, 2));
            if (bus8.out_ready) void'(sb_q.pop_front());
         end
         err_exp = 1'b0;
         if (bus8.in_valid && bus8.in_ready) begin
            r = op_model(bus8.ctrl_op, bus8.data_operandA, bus8.data_operandB);
            if (bus8.in_first || !m_active) begin
               if (bus8.in_first && m_active) err_exp = 1'b1;
               m_acc = r;
               m_cnt = 1;
            end else begin
               m_acc = op_model(bus8.ctrl_op, m_acc, r);
               m_cnt++;
            end
            if (bus8.in_last) begin
               sb_q.push_back('{m_acc, m_cnt});
               m_active = 1'b0;
            end else begin
               m_active = 1'b1;
            end
         end
      end
   end

   task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic first, input logic last);
      bit accepted;
      accepted = 0;
      @(posedge clock);
      #1;
      bus8.in_valid      = 1'b1;
      bus8.ctrl_op       = op;
      bus8.data_operandA = a;
      bus8.data_operandB = b;
      bus8.in_first      = first;
      bus8.in_last       = last;
      for (int t = 0; t < 50; t++) begin
         @(negedge clock);
         if (bus8.in_ready) begin
            accepted = 1;
            break;
         end
      end
      n_checks++;
      if (accepted) n_pass++;
      else $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
      @(posedge clock);
      #1;
      bus8.in_valid = 1'b0;
   endtask

   task automatic check_output(input string name, input logic [31:0] exp_val, input int exp_cnt,
                               input logic exp_err);
      @(negedge clock);
      check({name, "_valid"}, 32'(bus8.out_valid), 32'h1);
      check({name, "_result"}, bus8.result, exp_val);
      check({name, "_count"}, 32'(bus8.beat_count), 32'(exp_cnt));
      check({name, "_count_w2"}, 32'(bus2.beat_count), sat_cnt(exp_cnt, 2));
      check({name, "_zero"}, 32'(bus8.result_zero), 32'(exp_val == 32'h0));
      check({name, "_ones"}, 32'(bus8.result_ones), 32'(exp_val == 32'hFFFF_FFFF));
      check({name, "_err"}, 32'(bus8.err_restart), 32'(exp_err));
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_valid"}, 32'(bus8.out_valid), 32'h0);
      check({name, "_result"}, bus8.result, 32'h0);
      check({name, "_zero"}, 32'(bus8.result_zero), 32'h0);
      check({name, "_ones"}, 32'(bus8.result_ones), 32'h0);
      check({name, "_count"}, 32'(bus8.beat_count), 32'h0);
      check({name, "_count_w2"}, 32'(bus2.beat_count), 32'h0);
      check({name, "_err"}, 32'(bus8.err_restart), 32'h0);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset_n       = 1'b0;
      bus8.in_valid = 1'b0;
      sb_q.delete();
      err_exp  = 1'b0;
      m_active = 1'b0;
      #1;
      check_reset_state("midreset");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] xv;
      logic        f;
      int          len;
      clock = 0;
      reset_n = 0;
      rand_ready = 0;
      dir_ready = 1;
      bus8.in_valid = 0;
      bus8.ctrl_op = OP_AND;
      bus8.data_operandA = '0;
      bus8.data_operandB = '0;
      bus8.in_first = 0;
      bus8.in_last = 0;
      m_acc = '0;
      m_cnt = 0;
      m_active = 0;
      err_exp = 0;
      n_checks = 0;
      n_pass = 0;

      #12;
      check_reset_state("reset");
      reset_n = 1;

      apply_stimulus(OP_OR, 32'h0000_00F0, 32'h0000_000F, 1, 1);
      check_output("single_or", 32'h0000_00FF, 1, 0);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 1);
         check_output($sformatf("op%0d", i), op_exp[i], 1, 0);
      end

      apply_stimulus(OP_OR, 32'h1, 32'h2, 1, 0);
      apply_stimulus(OP_OR, 32'h4, 32'h0, 0, 0);
      apply_stimulus(OP_OR, 32'h0, 32'h80, 0, 1);
      check_output("group3_or", 32'h87, 3, 0);

      // Backpressure: hold a result, offer another last beat, then release.
      @(posedge clock);
      #1;
      dir_ready = 0;
      apply_stimulus(OP_XOR, 32'hAA, 32'h55, 1, 1);
      bus8.in_valid      = 1'b1;
      bus8.ctrl_op       = OP_AND;
      bus8.data_operandA = 32'hF0;
      bus8.data_operandB = 32'h3C;
      bus8.in_first      = 1'b1;
      bus8.in_last       = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("bp_in_ready", 32'(bus8.in_ready), 32'h0);
         check("bp_hold_result", bus8.result, 32'hFF);
         check("bp_hold_valid", 32'(bus8.out_valid), 32'h1);
      end
      @(posedge clock);
      #1;
      dir_ready = 1;
      @(negedge clock);
      check("bp_release_ready", 32'(bus8.in_ready), 32'h1);
      @(posedge clock);
      #1;
      bus8.in_valid = 1'b0;
      @(negedge clock);
      check("b2b_valid", 32'(bus8.out_valid), 32'h1);
      check("b2b_result", bus8.result, 32'h30);

      apply_stimulus(OP_XOR, 32'hFF, 32'h0F, 1, 0);
      apply_stimulus(OP_AND, 32'hFF, 32'h3C, 1, 1);
      check_output("restart", 32'h3C, 1, 1);

      apply_stimulus(OP_AND, 32'h0, 32'h0, 1, 1);
      check_output("zero_flag", 32'h0, 1, 0);
      xv = $urandom;
      apply_stimulus(OP_XNOR, xv, xv, 1, 1);
      check_output("ones_flag", 32'hFFFF_FFFF, 1, 0);

      for (int k = 0; k < 5; k++) begin
         apply_stimulus(OP_OR, 32'h1 << k, 32'h0, k == 0, k == 4);
      end
      check_output("group5_sat", 32'h1F, 5, 0);

      apply_stimulus(OP_OR, 32'h11, 32'h0, 1, 0);
      apply_stimulus(OP_OR, 32'h22, 32'h0, 0, 0);
      do_reset();
      apply_stimulus(OP_PASSA, 32'h5A, 32'h0, 0, 1);
      check_output("after_reset", 32'h5A, 1, 0);

      rand_ready = 1;
      for (int g = 0; g < 60; g++) begin
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) begin
            op = 3'($urandom_range(0, 7));
            f  = (k == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 9) == 0);
            apply_stimulus(op, $urandom, $urandom, f, k == len - 1);
         end
      end
      @(posedge clock);
      #1;
      rand_ready = 0;
      dir_ready  = 1;
      repeat (5) @(posedge clock);
      #1;
      check("drain_empty", 32'(sb_q.size()), 32'h0);

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bitwise_logic_accum.md
Name: bitwise_logic_accum

Overview:
Parametrised, handshaked bitwise logic unit, successor to the fixed 32-bit two-input OR. Per accepted beat it applies one of eight selectable bitwise operations to two WIDTH-bit operands. It optionally folds a multi-beat group into a running accumulator, for example to build letter masks across several words. It sits beside the ALU and emits one registered result per group, with zero/all-ones flags and a beat count.

Parameters:
WIDTH, 32, operand/result width in bits (>=1)
CNT_W, 8, width of beat_count; saturating

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat
data_operandA  input  WIDTH  operand A
data_operandB  input  WIDTH  operand B
ctrl_op  input  3  operation select
in_first  input  1  beat opens a group
in_last  input  1  beat closes a group and produces output
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  group result
result_zero  output  1  result == 0
result_ones  output  1  result == all ones
beat_count  output  CNT_W  beats folded into result, saturating at 2^CNT_W-1
err_restart  output  1  one-cycle pulse: in_first arrived while a group was open

Behaviour:
- Clock and reset: single clock domain, clock rising edge. reset_n is asynchronous, active-low.
- Reset values: out_valid=0, result=0, result_zero=0, result_ones=0, beat_count=0, err_restart=0; internal acc=0, acc_cnt=0, group_active=0. A reset asserted mid-group discards the group and any pending output.
- Op codes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 ANDN (A & ~B), 111 PASSA.
- Accept: a beat is accepted when in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready. This applies to all beats and is combinational from out_valid/out_ready only, never from in_valid.
- Beat result: r = OP(A,B), where OP is the ctrl_op sampled with that beat.
- Fold, first beat: if in_first || !group_active, then val = r and cnt = 1.
- Fold, later beats: otherwise val = OP(acc, r), using the same beat's ctrl_op, and cnt = sat(acc_cnt+1).
- Non-last accepted beat: acc<=val, acc_cnt<=cnt, group_active<=1. No output is produced.
- Last accepted beat: result<=val, beat_count<=cnt, result_zero<=(val==0), result_ones<=(val=={WIDTH{1}}), out_valid<=1, group_active<=0. Latency is 1 cycle from acceptance of the last beat to out_valid.
- Single-beat op: in_first=in_last=1 gives result = OP(A,B), beat_count=1.
- Restart: in_first=1 accepted while group_active=1 discards the open group, restarts from r, and pulses err_restart for exactly one cycle.
- in_last without an open group and with in_first=0: treated as a single-beat group. No error.
- Output hold: result, flags and beat_count are stable while out_valid && !out_ready.
- Output handoff: out_valid clears on out_valid && out_ready, unless a last beat is accepted in the same cycle. In that case out_valid stays 1 and the new result loads, giving full throughput.
- Saturation: beat_count saturates at 2^CNT_W-1 and never wraps.
- Unaccepted beats: inputs are ignored when not accepted. acc is unchanged.

Decomposition:
- Shared package logic_unit_pkg: 3-bit op-code constants (OP_AND..OP_PASSA) and the LU_OP_W=3 constant.
- Sub-module bitwise_op_comb (parameter WIDTH): purely combinational, takes (op, x, y) and returns WIDTH bits. It is instantiated twice: once for OP(A,B) and once for OP(acc,r).
- Top level: holds only the handshake, the accumulator, the counter and the output registers.

Test Plan:
- Reset, then single beat OR with A=0x0000_00F0, B=0x0000_000F, first=last=1 -> next cycle out_valid=1, result=0x0000_00FF, beat_count=1, result_zero=0.
- All eight ops with A=0xF0F0_F0F0, B=0xFF00_FF00, single-beat each -> AND 0xF000_F000, OR 0xFFF0_FFF0, XOR 0x0FF0_0FF0, NOR 0x000F_000F, NAND 0x0FFF_0FFF, XNOR 0xF00F_F00F, ANDN 0x00F0_00F0, PASSA 0xF0F0_F0F0.
- 3-beat OR group with pairs (0x1,0x2), (0x4,0x0), (0x0,0x80) -> one output: result=0x87, beat_count=3. No out_valid on beats 1–2.
- Backpressure: out_ready=0 with a result pending, then a new last beat offered -> in_ready=0 and result held stable. Raise out_ready with in_valid high -> back-to-back results, out_valid stays 1.
- Restart: open an XOR group (beat A=0xFF, B=0x0F), then in_first beat AND A=0xFF, B=0x3C with last=1 -> err_restart pulses once, result=0x3C, beat_count=1. Separately, AND A=B=0 gives result_zero=1, and XNOR A=B gives result_ones=1.
- CNT_W=2: 5-beat OR group -> beat_count=3 (saturated). Assert reset_n=0 mid-group -> all outputs return to 0 immediately, and a following single beat yields beat_count=1.
